led_panel_cmd_tx: RTL

LED_PANEL_CMD_TX -- requirements
Module: led_panel_cmd_tx

---
 rtl/led_panel_cmd_tx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/led_panel_cmd_tx.sv
// rtl/led_panel_cmd_tx.sv - serializes LED panel commands as one or two 8N1 UART bytes
// Pixel commands carry a second byte, optionally preceded by an idle-high gap.
module led_panel_cmd_tx #(
   parameter int CLKS_PER_BIT = 20,
   parameter int GAP_CLKS     = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   input  logic [2:0] cmd_rgb,
   input  logic [3:0] cmd_col,
   input  logic [2:0] cmd_row,
   output logic       cmd_ready,
   output logic       cmd_done,
   output logic       busy,
   output logic       uart_tx
);

   localparam int CNT_MAX = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
   localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    next_q, next_d;
   logic          pend_q, pend_d;
   logic          tx_q, tx_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      next_d  = next_q;
      pend_d  = pend_q;
      tx_d    = tx_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  2'b00: begin
                     byte_d = {5'b00000, cmd_rgb};
                     pend_d = 1'b0;
                  end
                  2'b01: begin
                     byte_d = 8'h10;
                     next_d = {cmd_col, 1'b0, cmd_row};
                     pend_d = 1'b1;
                  end
                  2'b10: begin
                     byte_d = 8'h20;
                     next_d = {cmd_col, 1'b0, cmd_row};
                     pend_d = 1'b1;
                  end
                  default: begin
                     byte_d = 8'h30;
                     pend_d = 1'b0;
                  end
               endcase
               state_d = ST_START;
               cnt_d   = '0;
               bit_d   = 3'd0;
               tx_d    = 1'b0;
            end
         end

         ST_START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = ST_DATA;
               tx_d    = byte_q[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = byte_q[bit_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (pend_q) begin
                  pend_d = 1'b0;
                  byte_d = next_q;
                  if (GAP_CLKS > 0) begin
                     state_d = ST_GAP;
                     tx_d    = 1'b1;
                  end else begin
                     state_d = ST_START;
                     tx_d    = 1'b0;
                  end
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_START;
               tx_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            // Unreachable encodings park safely with the line released.
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = 3'd0;
            pend_d  = 1'b0;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         bit_q   <= 3'd0;
         cnt_q   <= '0;
         byte_q  <= 8'h00;
         next_q  <= 8'h00;
         pend_q  <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         next_q  <= next_d;
         pend_q  <= pend_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = ~cmd_ready;
   assign cmd_done  = done_q;
   assign uart_tx   = tx_q;

endmodule
